// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad far-end model: state codes, scan codes,
// LFSR polynomial and key-index field helpers.
package keypad_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'b0001,
        BOUNCE_IN  = 4'b0010,
        HOLD       = 4'b0100,
        BOUNCE_OUT = 4'b1000
    } kp_state_t;

    // Active-low column drive codes as produced by the scanner
    localparam logic [3:0] CIDLE    = 4'b0000;
    localparam logic [3:0] C3       = 4'b0111;
    localparam logic [3:0] C2       = 4'b1011;
    localparam logic [3:0] C1       = 4'b1101;
    localparam logic [3:0] C0       = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int KEY_R_LSB = 2;
    localparam int KEY_C_LSB = 0;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[KEY_R_LSB +: 2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[KEY_C_LSB +: 2];
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 8-bit Fibonacci LFSR producing a 1..8 cycle segment length
// for bounce generation; reusable by other noise models.
module bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       i_en,
    output logic [3:0] o_seg
);

    logic [7:0] r_lfsr;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign o_seg = {1'b0, r_lfsr[2:0]} + 4'd1;

endmodule

// File: rtl/keypad_matrix_model.sv
// Far-end model of a 4x4 membrane keypad: plays one commanded key press with
// programmable press bounce, hold time and release bounce onto the row lines.
module keypad_matrix_model
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED   = 8'hA5,
    parameter int         HOLD_W = 16,
    parameter int         BN_W   = 4,
    parameter int         PCNT_W = 8
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [BN_W-1:0]   cmd_bounce,
    input  logic              cmd_abort,
    output logic              contact,
    output logic [PCNT_W-1:0] press_cnt,
    output logic [3:0]        state_view
);

    kp_state_t         r_state, w_state_nxt;
    logic              r_contact, w_contact_nxt;
    logic [3:0]        r_key;
    logic [HOLD_W-1:0] r_hold;
    logic [BN_W-1:0]   r_bounce;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [BN_W-1:0]   r_pair_cnt, w_pair_cnt_nxt;
    logic [3:0]        r_seg_cnt, w_seg_cnt_nxt;
    logic [PCNT_W-1:0] r_press_cnt, w_press_cnt_nxt;
    logic [3:0]        w_seg;
    logic              w_accept;
    logic [HOLD_W-1:0] w_cmd_hold_len;
    logic [HOLD_W-1:0] w_hold_len;

    bounce_lfsr #(.SEED(SEED)) u_lfsr (
        .CLK   (CLK),
        .rst   (rst),
        .i_en  (1'b1),
        .o_seg (w_seg)
    );

    assign w_accept       = cmd_valid && (r_state == IDLE);
    assign w_cmd_hold_len = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
    assign w_hold_len     = (r_hold == '0) ? HOLD_W'(1) : r_hold;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_contact   <= 1'b0;
            r_hold_cnt  <= '0;
            r_pair_cnt  <= '0;
            r_seg_cnt   <= '0;
            r_press_cnt <= '0;
            r_key       <= '0;
            r_hold      <= '0;
            r_bounce    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_contact   <= w_contact_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_pair_cnt  <= w_pair_cnt_nxt;
            r_seg_cnt   <= w_seg_cnt_nxt;
            r_press_cnt <= w_press_cnt_nxt;
            if (w_accept) begin
                r_key    <= cmd_key;
                r_hold   <= cmd_hold;
                r_bounce <= cmd_bounce;
            end
        end
    end

    // During bounce the contact register doubles as the closed/open phase flag
    always_comb begin
        w_state_nxt     = r_state;
        w_contact_nxt   = r_contact;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_pair_cnt_nxt  = r_pair_cnt;
        w_seg_cnt_nxt   = r_seg_cnt;
        w_press_cnt_nxt = r_press_cnt;
        if (cmd_abort && (r_state != IDLE)) begin
            w_state_nxt   = IDLE;
            w_contact_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        w_contact_nxt = 1'b1;
                        if (cmd_bounce == '0) begin
                            w_state_nxt    = HOLD;
                            w_hold_cnt_nxt = w_cmd_hold_len;
                        end else begin
                            w_state_nxt    = BOUNCE_IN;
                            w_pair_cnt_nxt = cmd_bounce;
                            w_seg_cnt_nxt  = w_seg;
                        end
                    end
                end
                BOUNCE_IN: begin
                    if (r_seg_cnt > 4'd1) begin
                        w_seg_cnt_nxt = r_seg_cnt - 4'd1;
                    end else if (r_contact) begin
                        w_contact_nxt = 1'b0;
                        w_seg_cnt_nxt = w_seg;
                    end else if (r_pair_cnt <= BN_W'(1)) begin
                        w_state_nxt    = HOLD;
                        w_contact_nxt  = 1'b1;
                        w_hold_cnt_nxt = w_hold_len;
                    end else begin
                        w_pair_cnt_nxt = r_pair_cnt - BN_W'(1);
                        w_contact_nxt  = 1'b1;
                        w_seg_cnt_nxt  = w_seg;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt > HOLD_W'(1)) begin
                        w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                    end else begin
                        w_contact_nxt = 1'b0;
                        if (r_bounce == '0) begin
                            w_state_nxt     = IDLE;
                            w_press_cnt_nxt = r_press_cnt + PCNT_W'(1);
                        end else begin
                            w_state_nxt    = BOUNCE_OUT;
                            w_pair_cnt_nxt = r_bounce;
                            w_seg_cnt_nxt  = w_seg;
                        end
                    end
                end
                BOUNCE_OUT: begin
                    if (r_seg_cnt > 4'd1) begin
                        w_seg_cnt_nxt = r_seg_cnt - 4'd1;
                    end else if (!r_contact) begin
                        w_contact_nxt = 1'b1;
                        w_seg_cnt_nxt = w_seg;
                    end else if (r_pair_cnt <= BN_W'(1)) begin
                        w_state_nxt     = IDLE;
                        w_contact_nxt   = 1'b0;
                        w_press_cnt_nxt = r_press_cnt + PCNT_W'(1);
                    end else begin
                        w_pair_cnt_nxt = r_pair_cnt - BN_W'(1);
                        w_contact_nxt  = 1'b0;
                        w_seg_cnt_nxt  = w_seg;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_contact_nxt = 1'b0;
                end
            endcase
        end
    end

    // Unregistered so the scanner sees its own column drive reflected this cycle
    always_comb begin
        row = ROW_IDLE;
        if (r_contact && !col[key_col(r_key)]) begin
            row[key_row(r_key)] = 1'b0;
        end
    end

    assign cmd_ready  = (r_state == IDLE);
    assign contact    = r_contact;
    assign press_cnt  = r_press_cnt;
    assign state_view = r_state;

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Self-checking bench for keypad_matrix_model: reset, timed presses, column
// decode, abort/ignore handling, LFSR-timed bounce and counter wrap.
module tb_keypad_matrix_model;
    import keypad_pkg::*;

    localparam int         HOLD_W  = 16;
    localparam int         BN_W    = 4;
    localparam int         PCNT_W  = 8;
    localparam logic [7:0] SEED_TB = 8'hA5;
    localparam int         CAP     = 300;

    logic              CLK, rst;
    logic [3:0]        col, row;
    logic              cmd_valid, cmd_ready, cmd_abort, contact;
    logic [3:0]        cmd_key, state_view;
    logic [HOLD_W-1:0] cmd_hold;
    logic [BN_W-1:0]   cmd_bounce;
    logic [PCNT_W-1:0] press_cnt;

    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_cnt = 0;
    logic [3:0] sb_q[$];
    logic [7:0] m_lfsr;
    logic       cap_low [CAP];
    logic [7:0] cap_lfsr [CAP];

    typedef struct {
        logic [3:0] col;
        logic [3:0] exp_row;
    } vec_t;
    vec_t vecs [7];

    keypad_matrix_model #(
        .SEED(SEED_TB), .HOLD_W(HOLD_W), .BN_W(BN_W), .PCNT_W(PCNT_W)
    ) dut (
        .CLK(CLK), .rst(rst), .col(col), .row(row),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_hold(cmd_hold), .cmd_bounce(cmd_bounce), .cmd_abort(cmd_abort),
        .contact(contact), .press_cnt(press_cnt), .state_view(state_view)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference LFSR: x^8+x^6+x^5+x^4+1, stepping every clock out of reset
    always @(posedge CLK or posedge rst) begin
        if (rst) m_lfsr <= SEED_TB;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offers a command in cycle t (capture index 0), returns just after edge t
    task automatic issue(input logic [3:0] key, input int hold, input int bn);
        @(negedge CLK);
        cmd_key    = key;
        cmd_hold   = hold[HOLD_W-1:0];
        cmd_bounce = bn[BN_W-1:0];
        cmd_valid  = 1'b1;
        cap_low[0]  = (row != ROW_IDLE);
        cap_lfsr[0] = m_lfsr;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic capture();
        for (int k = 1; k < CAP; k++) begin
            @(negedge CLK);
            cap_low[k]  = (row != ROW_IDLE);
            cap_lfsr[k] = m_lfsr;
        end
    endtask

    // Splits the captured row trace into runs and checks each bounce segment
    // against the reference LFSR value sampled the cycle before it started.
    task automatic analyze_bounce(input string tag, input int bn, input int hold, output int events);
        int   rs[$];
        int   rl[$];
        logic rv[$];
        int   s;
        int   opens;
        int   closes;
        s = 1;
        events = 0;
        opens = 0;
        closes = 0;
        for (int k = 2; k <= CAP; k++) begin
            if (k == CAP || cap_low[k] != cap_low[s]) begin
                rs.push_back(s);
                rl.push_back(k - s);
                rv.push_back(cap_low[s]);
                s = k;
            end
        end
        check({tag, "_runs"}, rs.size(), 4 * bn + 2);
        for (int i = 0; i < rs.size() && i < 4 * bn + 2; i++) begin
            if (rv[i] && rl[i] >= 16) events++;
            if (i == 2 * bn) begin
                check({tag, "_hold_len"}, rl[i], hold);
                check({tag, "_hold_lvl"}, rv[i], 1);
            end else if (i == 4 * bn + 1) begin
                check({tag, "_release_lvl"}, rv[i], 0);
            end else begin
                check({tag, "_seg_len"}, rl[i], {29'd0, cap_lfsr[rs[i] - 1][2:0]} + 1);
                if (i < 2 * bn && !rv[i]) opens++;
                if (i > 2 * bn && rv[i]) closes++;
            end
        end
        check({tag, "_open_glitches"}, opens, bn);
        check({tag, "_closed_glitches"}, closes, bn);
    endtask

    initial begin
        int ev;
        vecs = '{
            '{4'b0000, 4'b1011}, '{4'b0111, 4'b1111}, '{4'b1011, 4'b1111},
            '{4'b1101, 4'b1011}, '{4'b1110, 4'b1111}, '{4'b0101, 4'b1011},
            '{4'b1010, 4'b1111}
        };
        rst = 1'b1;
        col = ROW_IDLE;
        cmd_valid = 1'b0;
        cmd_abort = 1'b0;
        cmd_key = '0;
        cmd_hold = '0;
        cmd_bounce = '0;

        #12;
        check("rst_row", row, ROW_IDLE);
        check("rst_contact", contact, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_cnt", press_cnt, 0);
        check("rst_state", state_view, IDLE);
        @(negedge CLK) rst = 1'b0;

        // Asynchronous reset in the middle of a long hold
        col = CIDLE;
        issue(4'b0000, 1000, 0);
        repeat (4) @(negedge CLK);
        check("prerst_row", row, 4'b1110);
        #2 rst = 1'b1;
        #1;
        check("midrst_row", row, ROW_IDLE);
        check("midrst_contact", contact, 0);
        @(negedge CLK) rst = 1'b0;
        @(negedge CLK);
        check("postrst_ready", cmd_ready, 1);
        check("postrst_cnt", press_cnt, 0);

        // Deterministic press: key r=0,c=3, hold 40, column 3 driven
        col = C3;
        issue(4'b0011, 40, 0);
        for (int k = 1; k <= 50; k++) sb_q.push_back((k <= 40) ? 4'b1110 : ROW_IDLE);
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            check("det_row", row, sb_q.pop_front());
            if (k == 40) check("det_ready_busy", cmd_ready, 0);
            if (k == 41) check("det_ready_back", cmd_ready, 1);
        end
        exp_cnt++;
        check("det_cnt", press_cnt, exp_cnt);

        // Same key with a different column driven: never visible on rows
        col = C2;
        issue(4'b0011, 40, 0);
        for (int k = 1; k <= 50; k++) sb_q.push_back(ROW_IDLE);
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            check("c2_row", row, sb_q.pop_front());
            if (k == 1) check("c2_contact", contact, 1);
        end
        exp_cnt++;
        check("c2_cnt", press_cnt, exp_cnt);

        // Column selectivity on key r=2,c=1 held
        issue(4'b1001, 1000, 0);
        foreach (vecs[i]) begin
            @(posedge CLK);
            #1 col = vecs[i].col;
            sb_q.push_back(vecs[i].exp_row);
            @(negedge CLK);
            check("colsel_row", row, sb_q.pop_front());
        end
        check("hold_ready", cmd_ready, 0);

        // A second command during HOLD must not replace the latched key
        @(negedge CLK);
        cmd_key = 4'b0000;
        cmd_hold = 16'd5;
        cmd_valid = 1'b1;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        col = C0;
        @(negedge CLK);
        check("ignore_c0", row, ROW_IDLE);
        col = C1;
        @(negedge CLK);
        check("ignore_c1", row, 4'b1011);
        check("ignore_state", state_view, HOLD);

        cmd_abort = 1'b1;
        @(posedge CLK);
        #1 cmd_abort = 1'b0;
        @(negedge CLK);
        check("abort_hold_row", row, ROW_IDLE);
        check("abort_hold_state", state_view, IDLE);
        check("abort_hold_cnt", press_cnt, exp_cnt);

        // Abort during BOUNCE_IN
        col = CIDLE;
        issue(4'b0110, 100, 3);
        @(negedge CLK);
        check("bin_state", state_view, BOUNCE_IN);
        check("bin_contact", contact, 1);
        cmd_abort = 1'b1;
        @(posedge CLK);
        #1 cmd_abort = 1'b0;
        @(negedge CLK);
        check("abort_bin_row", row, ROW_IDLE);
        check("abort_bin_state", state_view, IDLE);
        check("abort_bin_cnt", press_cnt, exp_cnt);

        // Abort in IDLE is ignored even alongside a valid command
        @(negedge CLK);
        cmd_key = 4'b0000;
        cmd_hold = 16'd3;
        cmd_bounce = '0;
        cmd_valid = 1'b1;
        cmd_abort = 1'b1;
        @(posedge CLK);
        #1 begin cmd_valid = 1'b0; cmd_abort = 1'b0; end
        @(negedge CLK);
        check("idle_abort_state", state_view, HOLD);
        repeat (5) @(negedge CLK);
        exp_cnt++;
        check("idle_abort_cnt", press_cnt, exp_cnt);

        // LFSR-timed bounce, 3 pairs around a 100-cycle hold
        col = CIDLE;
        issue(4'b1111, 100, 3);
        capture();
        analyze_bounce("b3", 3, 100, ev);
        exp_cnt++;
        check("b3_cnt", press_cnt, exp_cnt);
        check("b3_state", state_view, IDLE);

        // Scanner-style view: column 3 driven, debounced events counted
        col = C3;
        issue(4'b0011, 200, 2);
        capture();
        analyze_bounce("b2", 2, 200, ev);
        check("b2_key_events", ev, 1);
        exp_cnt++;
        check("b2_cnt", press_cnt, exp_cnt);

        // 256 minimum presses (hold 0 acts as 1) wrap the counter
        col = CIDLE;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            cmd_key = 4'b0101;
            cmd_hold = '0;
            cmd_bounce = '0;
            cmd_valid = 1'b1;
            @(posedge CLK);
            #1 cmd_valid = 1'b0;
            @(negedge CLK);
            if (i == 0) check("h0_contact_on", contact, 1);
            @(negedge CLK);
            if (i == 0) begin
                check("h0_contact_off", contact, 0);
                check("h0_ready", cmd_ready, 1);
            end
            exp_cnt++;
            if (i == 255 - (exp_cnt - 1 - i)) check("wrap_zero", press_cnt, 0);
        end
        check("wrap_cnt", press_cnt, exp_cnt % 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_model.md
Name: keypad_matrix_model

Overview:
Behavioural-synthesizable model of the 4x4 membrane keypad on the far end of the col/row scan interface. It receives the active-low column drive and returns the active-low row lines for one pressed key. The key has programmable press bounce, hold duration and release bounce. It drives the keypad scanner in closed-loop benches and in the FPGA self-test build, where a command source plays key sequences into the coin charger.

Parameters:
SEED, 8'hA5, non-zero LFSR seed for bounce segment lengths
HOLD_W, 16, width of hold-duration field
BN_W, 4, width of bounce-pair count field
PCNT_W, 8, width of completed-press counter

Ports:
CLK  input  1  scan clock (same clock as the keypad scanner)
rst  input  1  reset; asynchronous, active-high
col  input  4  column drive from scanner, active-low (0000 = all columns driven)
row  output  4  row return to scanner, active-low, 1111 = no contact
cmd_valid  input  1  press command offered
cmd_ready  output  1  model can accept a command
cmd_key  input  4  key index: [3:2] row index r, [1:0] column index c
cmd_hold  input  HOLD_W  stable-closed cycles; 0 treated as 1
cmd_bounce  input  BN_W  number of glitch pairs on press and on release
cmd_abort  input  1  force immediate release
contact  output  1  internal switch closed
press_cnt  output  PCNT_W  completed presses (wraps)
state_view  output  4  current state, debug

Behaviour:
- States (one-hot): IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT.
- Reset (async): state=IDLE, contact=0, row=1111, press_cnt=0, LFSR=SEED, key/hold/bounce registers=0, cmd_ready=1.
- Row mapping (combinational): row[i]=0 iff contact=1, i==key_r and col[key_c]==0; else 1. Row follows col in the same cycle with no register stage, so the scanner sees its drive immediately.
- Handshake: cmd_ready=1 only in IDLE. Accept on cmd_valid&&cmd_ready at edge t.
  - key/hold/bounce are latched at edge t.
  - cmd_valid outside IDLE is ignored, not queued.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle after reset. Segment length seg=lfsr[2:0]+1 (1..8), sampled when a segment loads.
- IDLE -> accept:
  - if bounce=0: HOLD with contact=1 from cycle t+1.
  - else: BOUNCE_IN with contact=1 from t+1.
- BOUNCE_IN: alternates closed seg / open seg, bounce pairs in total. It then enters HOLD with contact=1 and no gap cycle.
- HOLD: contact=1 for exactly max(hold,1) cycles.
  - bounce=0: IDLE.
  - else: BOUNCE_OUT.
- BOUNCE_OUT: alternates open seg / closed seg, bounce pairs, then IDLE.
- Release: contact=0 from the first cycle after HOLD or BOUNCE_OUT ends.
- press_cnt increments by 1 on the HOLD/BOUNCE_OUT -> IDLE transition and wraps from 2^PCNT_W-1 to 0.
- cmd_abort in any non-IDLE state:
  - next cycle: IDLE, contact=0.
  - press_cnt is not incremented.
  - abort has priority over every transition.
  - abort in IDLE has no effect and is ignored even when cmd_valid is high in the same cycle.
- Total press length with bounce=0: hold cycles exactly. cmd_ready rises on the cycle after the last contact=1 cycle.
- col with multiple zeros: row is asserted if col[key_c]=0, regardless of other columns.
- col=0000 while contact=1 asserts row[key_r]. This is the scanner's press-detect condition.
- Reset mid-press drops row to 1111 asynchronously. No count is recorded.

Decomposition:
- Package keypad_pkg:
  - state encodings.
  - column codes CIDLE=0000, C3=0111, C2=1011, C1=1101, C0=1110; ROW_IDLE=1111.
  - LFSR tap mask.
  - key-index field positions.
- Sub-module bounce_lfsr: 8-bit LFSR with seed parameter, enable, and outputs seg[3:0]. It is shared with future noise models.

Test Plan:
- Reset and idle: assert rst mid-HOLD -> row=1111, contact=0 immediately; after release cmd_ready=1, press_cnt=0.
- Deterministic press: cmd_key=4'b0011 (r=0,c=3), hold=40, bounce=0, col=0111 -> row=1110 for exactly 40 cycles from t+1. Then row=1111, press_cnt=1. With col=1011 held, row=1111 throughout.
- Column selectivity: key 4'b1001 (r=2,c=1) held, sweep col 0000/0111/1011/1101/1110 -> row 1011/1111/1111/1011/1111.
- Bounce: SEED=8'hA5, bounce=3, hold=100, col=0000:
  - exactly 3 open glitches before the stable 100-cycle low.
  - 3 closed glitches after it.
  - every segment 1..8 cycles.
  - press_cnt=1 at end.
- Abort and ignore: cmd_abort during BOUNCE_IN -> next cycle row=1111, IDLE, press_cnt unchanged. A second cmd_valid during HOLD is ignored (latched key unchanged).
- Closed loop with keypad scanner: key 4'b0011, hold=200, bounce=2 -> scanner reports exactly one key event. Wrap check: 256 presses with PCNT_W=8 -> press_cnt=0.
